// File: rtl/rr_pkg.sv
// Shared types, default sizing and width helpers for the round-robin grant scheduler.
package rr_pkg;

    localparam int unsigned DEF_CHANNELS = 8;
    localparam int unsigned DEF_QUANTUM  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    // Tenure counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned quantum);
        return (quantum <= 2) ? 1 : $clog2(quantum);
    endfunction

    function automatic int unsigned id_width(input int unsigned channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between requesters (master) and the scheduler (slave).
interface rr_grant_scheduler_if
    import rr_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS
) ();
    localparam int unsigned IW = id_width(CHANNELS);

    logic                enable;
    logic [CHANNELS-1:0] request;
    logic                release_req;
    logic [CHANNELS-1:0] grant;
    logic [IW-1:0]       grant_id;
    logic                busy;
    logic                timeout;

    modport master (
        output enable, request, release_req,
        input  grant, grant_id, busy, timeout
    );

    modport slave (
        input  enable, request, release_req,
        output grant, grant_id, busy, timeout
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first set request at or after pointer+1, wrapping around.
module rr_priority_pick
    import rr_pkg::*;
#(
    parameter  int unsigned CHANNELS = DEF_CHANNELS,
    localparam int unsigned IW       = id_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] request,
    input  logic [IW-1:0]       pointer,
    output logic [CHANNELS-1:0] onehot,
    output logic [IW-1:0]       index
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            cand = IW'((32'(pointer) + i) % CHANNELS);
            if (!found && request[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                index        = cand;
            end
        end
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: one owner at a time, tenure ended by release, request drop or quantum.
module rr_grant_scheduler
    import rr_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned QUANTUM  = DEF_QUANTUM
) (
    input  logic                 clk,
    input  logic                 reset,
    rr_grant_scheduler_if.slave  bus
);

    localparam int unsigned IW = id_width(CHANNELS);
    localparam int unsigned CW = cnt_width(QUANTUM);
    localparam logic [CW-1:0] CNT_LAST = CW'(QUANTUM - 1);
    localparam logic [IW-1:0] PTR_RST  = IW'(CHANNELS - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [CHANNELS-1:0] grant_q, grant_d;
    logic [IW-1:0]       id_q, id_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;

    logic [CHANNELS-1:0] pick_onehot;
    logic [IW-1:0]       pick_index;

    rr_priority_pick #(.CHANNELS(CHANNELS)) u_pick (
        .request (bus.request),
        .pointer (ptr_q),
        .onehot  (pick_onehot),
        .index   (pick_index)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ptr_q     <= PTR_RST;
            grant_q   <= '0;
            id_q      <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state and next registered outputs; release outranks request drop outranks quantum.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        id_d      = id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable && (bus.request != '0)) begin
                    state_d = ST_HOLD;
                    grant_d = pick_onehot;
                    id_d    = pick_index;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (bus.release_req || !bus.request[id_q] || (cnt_q == CNT_LAST)) begin
                    state_d   = ST_IDLE;
                    ptr_d     = id_q;
                    grant_d   = '0;
                    id_d      = '0;
                    busy_d    = 1'b0;
                    timeout_d = !bus.release_req && bus.request[id_q];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                grant_d = '0;
                id_d    = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = id_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Bench for rr_grant_scheduler: directed scenarios plus random traffic against a tenure-level model.
module tb_rr_grant_scheduler;
    import rr_pkg::*;

    localparam int unsigned CH = 8;
    localparam int unsigned Q  = 16;
    localparam int unsigned IW = id_width(CH);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rr_grant_scheduler_if #(.CHANNELS(CH)) bus();

    rr_grant_scheduler #(.CHANNELS(CH), .QUANTUM(Q)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int   total = 0;
    int   bad   = 0;
    int   m_owner;
    int   m_ptr;
    int   m_held;
    logic m_timeout;
    logic prev_rel;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CH-1:0] exp_grant();
        return (m_owner < 0) ? '0 : (CH'(1) << m_owner);
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = CH - 1;
        m_held    = 0;
        m_timeout = 1'b0;
    endtask

    // One clock edge of the scheduler's behaviour, in terms of owner and cycles held.
    task automatic model_edge();
        logic [CH-1:0] r;
        r = bus.request;
        m_timeout = 1'b0;
        if (m_owner < 0) begin
            if (bus.enable && r != '0) begin
                for (int k = 1; k <= CH; k++) begin
                    int c;
                    c = (m_ptr + k) % CH;
                    if (m_owner < 0 && r[IW'(c)]) m_owner = c;
                end
                m_held = 1;
            end
        end else if (bus.release_req || !r[IW'(m_owner)] || m_held == Q) begin
            m_timeout = !bus.release_req && r[IW'(m_owner)];
            m_ptr     = m_owner;
            m_owner   = -1;
            m_held    = 0;
        end else begin
            m_held++;
        end
    endtask

    task automatic compare_outputs();
        check("grant",    32'(bus.grant),    32'(exp_grant()));
        check("grant_id", 32'(bus.grant_id), (m_owner < 0) ? 0 : m_owner);
        check("busy",     32'(bus.busy),     32'(m_owner >= 0));
        check("timeout",  32'(bus.timeout),  32'(m_timeout));
        check("onehot0",  32'($onehot0(bus.grant)), 1);
        check("id_match", 32'((bus.grant == (CH'(1) << bus.grant_id)) ||
                              (bus.grant == '0 && bus.grant_id == '0)), 1);
        check("busy_or",  32'(bus.busy == (|bus.grant)), 1);
        check("to_rel",   32'(bus.timeout & prev_rel), 0);
    endtask

    task automatic step();
        @(posedge clk);
        prev_rel = bus.release_req;
        if (!reset) model_reset();
        else        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        bus.enable      = 1'b0;
        bus.request     = '0;
        bus.release_req = 1'b0;
        prev_rel        = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int seen;
        @(negedge clk);
        do_reset();
        check("rst_ptr_grant", 32'(bus.grant), 0);

        // Two requesters, release hands over to the other after one idle cycle.
        bus.request = 8'b1000_0001;
        bus.enable  = 1'b1;
        step();
        check("t026_first", 32'(bus.grant), 32'h01);
        bus.release_req = 1'b1;
        step();
        bus.release_req = 1'b0;
        check("t026_idle", 32'(bus.grant), 0);
        step();
        check("t026_second", 32'(bus.grant), 32'h80);

        // All requesting, release each tenure: strict rotation 0..7,0.
        do_reset();
        bus.request = 8'hFF;
        bus.enable  = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            check("t027_order", 32'(bus.grant_id), i % CH);
            check("t027_grant", 32'(bus.grant), 32'(CH'(1) << (i % CH)));
            bus.release_req = 1'b1;
            step();
            bus.release_req = 1'b0;
            check("t027_idle", 32'(bus.busy), 0);
            step();
        end

        // Single requester, no release: quantum expiry and re-grant.
        do_reset();
        bus.request = 8'h04;
        bus.enable  = 1'b1;
        step();
        n = 1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (bus.grant != 8'h04) break;
            n++;
        end
        check("t028_len", n, Q);
        check("t028_timeout", 32'(bus.timeout), 1);
        check("t028_gap", 32'(bus.grant), 0);
        step();
        check("t028_regrant", 32'(bus.grant), 32'h04);
        check("t028_to_low", 32'(bus.timeout), 0);

        // Owner drops its request while another channel waits.
        do_reset();
        bus.request = 8'h08;
        bus.enable  = 1'b1;
        step();
        check("t029_own", 32'(bus.grant), 32'h08);
        step();
        step();
        bus.request = 8'h20;
        step();
        check("t029_drop", 32'(bus.grant), 0);
        step();
        check("t029_next", 32'(bus.grant), 32'h20);

        // Disabled scheduler stays idle; async reset mid-tenure.
        do_reset();
        bus.enable  = 1'b0;
        bus.request = 8'hFF;
        seen = 0;
        repeat (10) begin
            step();
            if (bus.grant != '0) seen++;
        end
        check("t030_disabled", seen, 0);
        bus.enable = 1'b1;
        step();
        step();
        bus.enable = 1'b0;
        step();
        check("t030_hold_en0", 32'(bus.grant), 32'h01);
        bus.enable = 1'b1;
        step();
        #2;
        reset = 1'b0;
        #1;
        check("t030_async_grant", 32'(bus.grant), 0);
        check("t030_async_busy", 32'(bus.busy), 0);
        check("t030_async_id", 32'(bus.grant_id), 0);
        model_reset();
        step();
        reset = 1'b1;
        step();
        check("t030_after_rst", 32'(bus.grant), 32'h01);

        // Random traffic with sticky requests so quantum expiries occur.
        do_reset();
        bus.request = CH'($urandom);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 99) < 6) bus.request = bus.request ^ (CH'(1) << $urandom_range(0, CH - 1));
            if ($urandom_range(0, 99) < 2) bus.request = CH'($urandom);
            bus.enable      = ($urandom_range(0, 99) < 85);
            bus.release_req = ($urandom_range(0, 99) < 4);
            reset           = ($urandom_range(0, 499) != 0);
            step();
        end
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_grant_scheduler.md
RR_GRANT_SCHEDULER -- requirements
Module: rr_grant_scheduler

Interface
REQ-001 Parameter CHANNELS, default 8, number of requesters (2..32).
REQ-002 Parameter QUANTUM, default 16, maximum grant tenure in cycles (2..256).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (reset==0 resets the block).
REQ-005 enable  input  1  1 = new grants may be issued; 0 = no new grants, current tenure continues.
REQ-006 request  input  CHANNELS  per-requester level request.
REQ-007 release  input  1  pulse from current owner ending its tenure; ignored when no grant is held.
REQ-008 grant  output  CHANNELS  registered one-hot grant, all-zero when idle.
REQ-009 grant_id  output  $clog2(CHANNELS)  binary index of the grant bit; 0 when idle.
REQ-010 busy  output  1  1 while any grant bit is set.
REQ-011 timeout  output  1  one-cycle pulse when a tenure is ended by quantum expiry.

Function
REQ-012 FSM states IDLE and HOLD; reset state IDLE.
- IDLE -> HOLD when enable==1 and request!=0.
- HOLD -> IDLE when a tenure ends (REQ-015).
- Any illegal encoding -> IDLE.
REQ-013 Winner selection is rotating priority: scan from index (pointer+1) upward with wrap-around; the first set request bit wins.
- Only one bit set: that bit wins regardless of pointer.
REQ-014 Grant latency is one cycle: request sampled in IDLE on edge N; grant/grant_id/busy valid after edge N+1.
REQ-015 Tenure end in HOLD, priority order:
- release==1;
- else request[grant_id]==0;
- else tenure counter==QUANTUM-1 (timeout pulse asserted for that same cycle's registered output).
REQ-016 Tenure counter: clears to 0 on grant issue, increments by 1 each HOLD cycle, width $clog2(QUANTUM), never wraps.
REQ-017 On tenure end, after the next edge: pointer <= grant_id, grant <= 0, busy <= 0; exactly one idle cycle precedes any new grant.
REQ-018 grant holds constant throughout HOLD; request changes on other channels do not affect it.
REQ-019 enable==0 in HOLD does not shorten the tenure; enable==0 in IDLE keeps grant==0.
REQ-020 release and timeout coinciding: treated as release; timeout stays 0.
REQ-021 grant shall never have more than one bit set; grant_id shall always equal the index of the set bit.

Reset
REQ-022 Asynchronous assertion, synchronous deassertion: on reset==0, state=IDLE, grant=0, grant_id=0, busy=0, timeout=0, counter=0, pointer=CHANNELS-1 (channel 0 wins first).
REQ-023 Reset mid-tenure drops grant immediately (no clock needed); the first post-reset grant follows REQ-014.

Structure
REQ-024 Package rr_pkg holds the state encoding typedef, default CHANNELS/QUANTUM constants and the counter width function.
REQ-025 Combinational sub-module rr_priority_pick(request, pointer -> onehot, index) implements REQ-013; instantiated once.

Verification
REQ-026 After reset, request=8'b1000_0001, enable=1 -> grant=8'b0000_0001 one cycle later; release -> idle cycle, then grant=8'b1000_0000.
REQ-027 request=8'hFF held, release pulsed once per tenure -> grant order 0,1,2,...,7,0 with one idle cycle between grants.
REQ-028 request=8'b0000_0100 held, no release, QUANTUM=16 -> grant held exactly 16 cycles, timeout pulse on the last cycle, re-grant to channel 2 after one idle cycle.
REQ-029 Owner channel 3 drops request mid-tenure while request[5]=1 -> grant=0 next cycle, then grant=8'b0010_0000.
REQ-030 enable=0 with request=8'hFF -> grant stays 0; reset pulled low during HOLD -> grant=0 asynchronously, pointer=7.
REQ-031 Assertions run in every test: grant one-hot-or-zero, grant_id consistent, busy==|grant, timeout never coincident with release.
